// File: rtl/axil_regfile_slave.sv
// AXI-Lite register bank responder.
// Exposes NUMBER_REG data-width registers to local logic. Each register is either
// read/write (flopped, byte-strobed) or read-only (sourced live from reg_in).
// Write and read channels run as independent engines, one transaction in flight each.
module axil_regfile_slave #(
   parameter int                        NUMBER_REG     = 16,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter logic [NUMBER_REG-1:0]     RO_MASK        = '0,
   parameter logic [AXI_DATA_WIDTH-1:0] RESET_VALUE    = '0
)(
   input  logic                                 aclk,
   input  logic                                 areset,
   input  logic [AXI_ADDR_WIDTH-1:0]            s_axil_awaddr,
   input  logic                                 s_axil_awvalid,
   output logic                                 s_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]            s_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]          s_axil_wstrb,
   input  logic                                 s_axil_wvalid,
   output logic                                 s_axil_wready,
   output logic [1:0]                           s_axil_bresp,
   output logic                                 s_axil_bvalid,
   input  logic                                 s_axil_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]            s_axil_araddr,
   input  logic                                 s_axil_arvalid,
   output logic                                 s_axil_arready,
   output logic [AXI_DATA_WIDTH-1:0]            s_axil_rdata,
   output logic [1:0]                           s_axil_rresp,
   output logic                                 s_axil_rvalid,
   input  logic                                 s_axil_rready,
   output logic [NUMBER_REG*AXI_DATA_WIDTH-1:0] reg_q,
   output logic [NUMBER_REG-1:0]                reg_wr_pulse,
   input  logic [NUMBER_REG*AXI_DATA_WIDTH-1:0] reg_in
);

   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                      aw_held;
   logic                      w_held;
   logic [IDX_W-1:0]          aw_idx_q;
   logic [AXI_DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]         w_strb_q;

   logic                      aw_hs;
   logic                      w_hs;
   logic                      ar_hs;
   logic                      commit;
   logic [IDX_W-1:0]          wr_idx;
   logic [AXI_DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]         wr_strb;
   logic [NUMBER_REG-1:0]     wr_sel;
   logic                      wr_ro;
   logic                      wr_ok;
   logic [IDX_W-1:0]          rd_idx;
   logic [AXI_DATA_WIDTH-1:0] rd_data;
   logic                      rd_hit;
   logic                      unused_addr_bits;

   // Byte-offset bits inside a word never select anything.
   assign unused_addr_bits = ^{s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

   // Readies are held off during reset and while a channel is occupied.
   assign s_axil_awready = !areset && !aw_held && !s_axil_bvalid;
   assign s_axil_wready  = !areset && !w_held  && !s_axil_bvalid;
   assign s_axil_arready = !areset && !s_axil_rvalid;

   assign aw_hs  = s_axil_awvalid && s_axil_awready;
   assign w_hs   = s_axil_wvalid  && s_axil_wready;
   assign ar_hs  = s_axil_arvalid && s_axil_arready;
   assign commit = !areset && !s_axil_bvalid && (aw_held || aw_hs) && (w_held || w_hs);

   // Pick the write address/data from the holding flops or straight off the bus, then decode.
   always_comb begin
      wr_idx  = aw_held ? aw_idx_q : s_axil_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
      wr_data = w_held  ? w_data_q : s_axil_wdata;
      wr_strb = w_held  ? w_strb_q : s_axil_wstrb;
      wr_sel  = '0;
      wr_ro   = 1'b0;
      for (int i = 0; i < NUMBER_REG; i++) begin
         if (wr_idx == IDX_W'(i)) begin
            wr_sel[i] = 1'b1;
            wr_ro     = RO_MASK[i];
         end
      end
      wr_ok = (|wr_sel) && !wr_ro;
   end

   // Read decode: R/W registers return their flops, read-only ones the live fabric input.
   always_comb begin
      rd_idx  = s_axil_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
      rd_data = '0;
      rd_hit  = 1'b0;
      for (int i = 0; i < NUMBER_REG; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_hit  = 1'b1;
            rd_data = RO_MASK[i] ? reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                                 : reg_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
         end
      end
   end

   // Write engine: capture AW/W independently, commit when both exist, hold B until accepted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_idx_q      <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
         reg_wr_pulse  <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= s_axil_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axil_wdata;
            w_strb_q <= s_axil_wstrb;
         end
         if (commit) begin
            aw_held       <= 1'b1;
            w_held        <= 1'b1;
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
               reg_wr_pulse <= wr_sel;
            end
         end else if (s_axil_bvalid && s_axil_bready) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axil_bvalid <= 1'b0;
         end
      end
   end

   // Register storage: byte-lane update of the selected R/W register on commit.
   always_ff @(posedge aclk) begin
      if (areset) begin
         reg_q <= {NUMBER_REG{RESET_VALUE}};
      end else if (commit && wr_ok) begin
         for (int i = 0; i < NUMBER_REG; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wr_sel[i] && !RO_MASK[i] && wr_strb[b]) begin
                  reg_q[i*AXI_DATA_WIDTH + b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end
      end
   end

   // Read engine: sample data on AR handshake, hold it until the R handshake.
   always_ff @(posedge aclk) begin
      if (areset) begin
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
         s_axil_rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         s_axil_rvalid <= 1'b1;
         s_axil_rdata  <= rd_data;
         s_axil_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_rvalid && s_axil_rready) begin
         s_axil_rvalid <= 1'b0;
      end
   end

endmodule
